interp_block_sequencer: RTL and testbench

//  Sequences one 8x8 subpixel interpolation block through the shared FIR_A/B/C datapath.
//  - Fills the 15-row input shift register through a valid/ready row handshake.
//  - Steps the input mux select across horizontal rows, then across vertical (temp_B) columns.
//  - Strobes the half-pel shift register and the output fillers, aligned to FIR latency.

---
 rtl/interp_seq_pkg.sv | 30 +++
 rtl/interp_seq_delay.sv | 36 +++
 rtl/interp_block_sequencer.sv | 137 +++++++++++++
 tb/tb_interp_block_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/interp_seq_pkg.sv
// Shared types and constants for the interpolation block sequencer.
// Holds the FSM state enum, block geometry and the strobe tag layout.
package interp_seq_pkg;

    localparam int NUM_PIXEL   = 8;
    localparam int TAPS        = 8;
    localparam int IN_ROWS     = NUM_PIXEL + TAPS - 1;
    localparam int FIR_LAT     = 2;
    localparam int VSEL_BASE   = 16;
    localparam int H_OUT_FIRST = 3;
    localparam int H_OUT_LAST  = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_HPASS,
        ST_VPASS,
        ST_DRAIN,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic       hb;
        logic       wr;
        logic [7:0] idx;
    } tag_t;

    localparam int TAG_W = $bits(tag_t);

endpackage

// File: rtl/interp_seq_delay.sv
// FIR-latency aligned tag pipe; flush clears every stage on the next edge.
// Ports: clk, rst (sync, active-low), flush, tag_in -> hb_shift_en, out_wr_en, out_idx.
module interp_seq_delay
    import interp_seq_pkg::*;
#(
    parameter int LAT = FIR_LAT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [TAG_W-1:0] tag_in,
    output logic             hb_shift_en,
    output logic             out_wr_en,
    output logic [7:0]       out_idx
);

    tag_t pipe [LAT];

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            for (int i = 0; i < LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= tag_t'(tag_in);
            for (int i = 1; i < LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign hb_shift_en = pipe[LAT-1].hb;
    assign out_wr_en   = pipe[LAT-1].wr;
    assign out_idx     = pipe[LAT-1].idx;

endmodule

// File: rtl/interp_block_sequencer.sv
// Sequences one 8x8 subpixel block: row fill, H pass, V pass, FIR drain.
// Ports: clk, rst (sync, active-low), start, abort, row_valid -> busy, done,
//   row_ready, in_shift_en, sel, hb_shift_en, out_wr_en, out_idx;
//   perf_cycles only when INTERP_SEQ_PERF_EN is defined.
module interp_block_sequencer
    import interp_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    input  logic        row_valid,
    output logic        row_ready,
    output logic        in_shift_en,
    output logic [7:0]  sel,
    output logic        hb_shift_en,
    output logic        out_wr_en,
    output logic [7:0]  out_idx
`ifdef INTERP_SEQ_PERF_EN
    ,
    output logic [15:0] perf_cycles
`endif
);

    localparam logic [7:0] ROW_LAST = 8'(IN_ROWS - 1);
    localparam logic [7:0] V_FIRST  = 8'(VSEL_BASE);
    localparam logic [7:0] V_LAST   = 8'(VSEL_BASE + NUM_PIXEL - 1);
    localparam logic [7:0] DRN_LAST = 8'(FIR_LAT - 1);

    state_t     state, state_nx;
    logic [7:0] cnt;
    tag_t       tag;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (abort) begin
            state_nx = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE:  if (start) state_nx = ST_FILL;
                ST_FILL:  if (in_shift_en && cnt == ROW_LAST) state_nx = ST_HPASS;
                ST_HPASS: if (sel == ROW_LAST) state_nx = ST_VPASS;
                ST_VPASS: if (sel == V_LAST) state_nx = ST_DRAIN;
                ST_DRAIN: if (cnt == DRN_LAST) state_nx = ST_DONE;
                ST_DONE:  state_nx = ST_IDLE;
                default:  state_nx = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy        = (state != ST_IDLE);
        done        = (state == ST_DONE);
        row_ready   = (state == ST_FILL);
        in_shift_en = row_ready && row_valid;
    end

    // cnt counts row handshakes in FILL and drain cycles in DRAIN;
    // it restarts on every state change.
    always_ff @(posedge clk) begin
        if (!rst || abort) begin
            cnt <= '0;
            sel <= '0;
        end else begin
            if (state_nx != state) begin
                cnt <= '0;
            end else if (in_shift_en || state == ST_DRAIN) begin
                cnt <= cnt + 8'd1;
            end
            if (state == ST_FILL && state_nx == ST_HPASS) begin
                sel <= '0;
            end else if (state == ST_HPASS) begin
                sel <= (state_nx == ST_VPASS) ? V_FIRST : sel + 8'd1;
            end else if (state == ST_VPASS && state_nx == ST_VPASS) begin
                sel <= sel + 8'd1;
            end
        end
    end

    // Tag describing what the select issued this cycle produces FIR_LAT later.
    always_comb begin
        tag = '0;
        if (state == ST_HPASS) begin
            tag.hb = 1'b1;
            if (sel >= 8'(H_OUT_FIRST) && sel <= 8'(H_OUT_LAST)) begin
                tag.wr  = 1'b1;
                tag.idx = sel - 8'(H_OUT_FIRST);
            end
        end else if (state == ST_VPASS) begin
            tag.wr  = 1'b1;
            tag.idx = sel - V_FIRST + 8'(NUM_PIXEL);
        end
    end

    interp_seq_delay #(
        .LAT (FIR_LAT)
    ) u_delay (
        .clk         (clk),
        .rst         (rst),
        .flush       (abort),
        .tag_in      (tag),
        .hb_shift_en (hb_shift_en),
        .out_wr_en   (out_wr_en),
        .out_idx     (out_idx)
    );

`ifdef INTERP_SEQ_PERF_EN
    logic [15:0] perf_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_cnt    <= '0;
            perf_cycles <= '0;
        end else begin
            if (state == ST_IDLE) begin
                perf_cnt <= '0;
            end else if (state != ST_DONE && perf_cnt != 16'hFFFF) begin
                perf_cnt <= perf_cnt + 16'd1;
            end
            if (state == ST_DONE && !abort) begin
                perf_cycles <= perf_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_interp_block_sequencer.sv
// Bench for interp_block_sequencer: table of block runs plus reset/abort sequences.
// Expected strobes are queued per block and popped as the DUT emits them.
module tb_interp_block_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic       busy;
    logic       done;
    logic       row_valid;
    logic       row_ready;
    logic       in_shift_en;
    logic [7:0] sel;
    logic       hb_shift_en;
    logic       out_wr_en;
    logic [7:0] out_idx;
`ifdef INTERP_SEQ_PERF_EN
    logic [15:0] perf_cycles;
    int          last_perf;
`endif

    interp_block_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .row_valid   (row_valid),
        .row_ready   (row_ready),
        .in_shift_en (in_shift_en),
        .sel         (sel),
        .hb_shift_en (hb_shift_en),
        .out_wr_en   (out_wr_en),
        .out_idx     (out_idx)
`ifdef INTERP_SEQ_PERF_EN
        ,
        .perf_cycles (perf_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit hb;
        bit wr;
        int idx;
    } strobe_t;

    typedef struct {
        int stall;
        int abort_k;
        bit hold;
        int exp_done;
    } vec_t;

    strobe_t sb[$];
    int      selq[$];
    vec_t    vecs[5];
    int      n_tests;
    int      n_fail;
    int      cur_t;
    int      sel_hold;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s t=%0d: got %0d expected %0d", nm, cur_t, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_block(input vec_t v);
        int      s_first;
        int      abort_t;
        int      last_t;
        int      rows;
        int      stalled;
        bit      e_busy;
        bit      e_rr;
        bit      stall_now;
        strobe_t e;
        sb.delete();
        selq.delete();
        for (int r = 0; r < 15; r++) begin
            e.hb  = 1'b1;
            e.wr  = (r >= 3 && r <= 10);
            e.idx = e.wr ? r - 3 : 0;
            sb.push_back(e);
            selq.push_back(r);
        end
        for (int k = 0; k < 8; k++) begin
            e.hb  = 1'b0;
            e.wr  = 1'b1;
            e.idx = 8 + k;
            sb.push_back(e);
            selq.push_back(16 + k);
        end
        s_first = 16 + v.stall;
        abort_t = (v.abort_k >= 0) ? 31 + v.abort_k : 100000;
        last_t  = (v.abort_k >= 0) ? abort_t + 4 : v.exp_done + 2;
        rows    = 0;
        stalled = 0;
        for (int t = 0; t <= last_t; t++) begin
            cur_t     = t;
            stall_now = (rows == 7 && stalled < v.stall);
            start     = (t == 0) || v.hold;
            abort     = (t == abort_t);
            row_valid = !stall_now;
            #2;
            if (stall_now) stalled++;
            if (in_shift_en && t < s_first) rows++;
            if (v.abort_k >= 0) begin
                e_busy = (t >= 1 && t <= abort_t);
            end else begin
                e_busy = (t >= 1 && t <= v.exp_done) ||
                         (v.hold && t >= v.exp_done + 2);
            end
            e_rr = (t >= 1 && t < s_first) ||
                   (v.hold && t >= v.exp_done + 2);
            chk("busy", int'(busy), int'(e_busy));
            chk("row_ready", int'(row_ready), int'(e_rr));
            chk("in_shift_en", int'(in_shift_en), int'(e_rr && row_valid));
            chk("done", int'(done), int'(t == v.exp_done));
            if (t > abort_t) begin
                chk("sel_abort", int'(sel), 0);
            end else if (t < s_first) begin
                chk("sel_hold", int'(sel), sel_hold);
            end else if (t <= s_first + 22) begin
                chk("sel_seq", int'(sel), selq[t - s_first]);
            end else begin
                chk("sel_last", int'(sel), 23);
            end
            if (t >= s_first + 2 && t <= s_first + 24 && t <= abort_t) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("hb_shift_en", int'(hb_shift_en), int'(e.hb));
                    chk("out_wr_en", int'(out_wr_en), int'(e.wr));
                    chk("out_idx", int'(out_idx), e.idx);
                end
            end else begin
                chk("hb_idle", int'(hb_shift_en), 0);
                chk("wr_idle", int'(out_wr_en), 0);
                chk("idx_idle", int'(out_idx), 0);
            end
            tick();
        end
        start     = 1'b0;
        abort     = 1'b0;
        row_valid = 1'b0;
        if (v.abort_k < 0) begin
            chk("rows_total", rows, 15);
            chk("sb_empty", sb.size(), 0);
            sel_hold = 23;
`ifdef INTERP_SEQ_PERF_EN
            if (!v.hold) begin
                chk("perf", int'(perf_cycles), v.exp_done - 1);
                last_perf = v.exp_done - 1;
            end
`endif
        end else begin
            sel_hold = 0;
`ifdef INTERP_SEQ_PERF_EN
            chk("perf_abort", int'(perf_cycles), last_perf);
`endif
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        cur_t     = -1;
        sel_hold  = 0;
`ifdef INTERP_SEQ_PERF_EN
        last_perf = 0;
`endif
        vecs[0] = '{stall: 0, abort_k: -1, hold: 1'b0, exp_done: 41};
        vecs[1] = '{stall: 5, abort_k: -1, hold: 1'b0, exp_done: 46};
        vecs[2] = '{stall: 0, abort_k: 3,  hold: 1'b0, exp_done: -1};
        vecs[3] = '{stall: 0, abort_k: -1, hold: 1'b0, exp_done: 41};
        vecs[4] = '{stall: 0, abort_k: -1, hold: 1'b1, exp_done: 41};

        rst       = 1'b0;
        start     = 1'b1;
        abort     = 1'b0;
        row_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_busy", int'(busy), 0);
            chk("rst_done", int'(done), 0);
            chk("rst_row_ready", int'(row_ready), 0);
            chk("rst_in_shift", int'(in_shift_en), 0);
            chk("rst_sel", int'(sel), 0);
            chk("rst_hb", int'(hb_shift_en), 0);
            chk("rst_wr", int'(out_wr_en), 0);
            chk("rst_idx", int'(out_idx), 0);
`ifdef INTERP_SEQ_PERF_EN
            chk("rst_perf", int'(perf_cycles), 0);
`endif
        end
        rst   = 1'b1;
        start = 1'b0;
        tick();
        chk("post_rst_busy", int'(busy), 0);

        for (int i = 0; i < 5; i++) begin
            run_block(vecs[i]);
        end

        cur_t = -2;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        #2;
        chk("hold_abort_busy", int'(busy), 0);
        chk("hold_abort_sel", int'(sel), 0);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        #2;
        chk("abort_over_start", int'(busy), 0);
`ifdef INTERP_SEQ_PERF_EN
        chk("perf_kept", int'(perf_cycles), last_perf);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
